fifo36_udp_dispatch: RTL and testbench



---
 rtl/fifo36_udp_dispatch_pkg.sv | 34 +++
 rtl/fifo36_udp_dispatch_hdr_match.sv | 23 ++
 rtl/fifo36_udp_dispatch.sv | 177 +++++++++++++++++
 tb/tb_fifo36_udp_dispatch.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo36_udp_dispatch_pkg.sv
// Purpose: shared types and field positions for the fifo36 UDP dispatcher.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo36_udp_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_REPLAY,
        ST_PASS
    } state_t;

    localparam int WORD_W      = 36;
    localparam int HDR_WORDS   = 10;

    // Header word positions inside the buffered frame start
    localparam int ETYPE_WORD  = 3;
    localparam int IPVER_WORD  = 3;
    localparam int PROTO_WORD  = 5;
    localparam int UDPDST_WORD = 9;

    // fifo36 control bit positions
    localparam int SOF_BIT     = 32;
    localparam int EOF_BIT     = 33;
    localparam int OCC_LSB     = 34;
    localparam int OCC_MSB     = 35;

    // IPv4 version 4 with a 20-byte header (IHL=5)
    localparam logic [7:0] IPV4_IHL5 = 8'h45;

    typedef logic [3:0] idx_t;
    typedef logic [HDR_WORDS-1:0][WORD_W-1:0] hdr_t;

endpackage

// File: rtl/fifo36_udp_dispatch_hdr_match.sv
// Purpose: decides whether a buffered frame header is IPv4/UDP to our port.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the result with its decision strobe.
module udp_hdr_match
    import fifo36_udp_dispatch_pkg::*;
#(
    parameter logic [15:0] MATCH_ETHERTYPE = 16'h0800,
    parameter logic [7:0]  MATCH_PROTO     = 8'h11
) (
    input  hdr_t        i_hdr,
    input  idx_t        i_n_words,
    input  logic [15:0] i_udp_port,
    output logic        o_route_a
);

    // Only a full 10-word header can qualify; anything shorter is a runt
    assign o_route_a = (i_n_words == idx_t'(HDR_WORDS))
                    && (i_hdr[ETYPE_WORD][31:16]  == MATCH_ETHERTYPE)
                    && (i_hdr[IPVER_WORD][15:8]   == IPV4_IHL5)
                    && (i_hdr[PROTO_WORD][7:0]    == MATCH_PROTO)
                    && (i_hdr[UDPDST_WORD][31:16] == i_udp_port);

endmodule

// File: rtl/fifo36_udp_dispatch.sv
// Purpose: buffers the first 10 fifo36 words of a frame, routes UDP-to-port frames to A, rest to B.
// Latency: first output word n cycles after input sof (n = buffered words), then zero-latency cut-through.
// Backpressure: input stalls during replay; in cut-through the selected output's dst_rdy drives in_dst_rdy.
module fifo36_udp_dispatch
    import fifo36_udp_dispatch_pkg::*;
#(
    parameter logic [15:0] MATCH_ETHERTYPE = 16'h0800,
    parameter logic [7:0]  MATCH_PROTO     = 8'h11
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [15:0] udp_port,
    input  logic [35:0] in_data,
    input  logic        in_src_rdy,
    output logic        in_dst_rdy,
    output logic [35:0] a_data,
    output logic        a_src_rdy,
    input  logic        a_dst_rdy,
    output logic [35:0] b_data,
    output logic        b_src_rdy,
    input  logic        b_dst_rdy,
    output logic [15:0] a_count,
    output logic [15:0] b_count
);

    state_t             r_state;
    state_t             w_next;
    logic [WORD_W-1:0]  r_buf [HDR_WORDS];
    idx_t               r_idx;
    idx_t               r_n;
    idx_t               r_rd;
    logic               r_sel_a;
    logic [15:0]        r_a_count;
    logic [15:0]        r_b_count;

    hdr_t               w_hdr;
    idx_t               w_n;
    logic               w_match_a;
    logic               w_first;
    logic               w_hdr_xfer;
    logic               w_decide;
    logic               w_out_rdy;
    logic               w_in_dst_rdy;
    logic               w_src_rdy;
    logic               w_eof;
    logic               w_last_rd;
    logic [WORD_W-1:0]  w_out_dat;

    // In IDLE and HDR the input is always ready, so in_src_rdy alone marks a transfer
    assign w_eof      = in_data[EOF_BIT];
    assign w_first    = (r_state == ST_IDLE) && in_src_rdy && in_data[SOF_BIT];
    assign w_hdr_xfer = (r_state == ST_HDR) && in_src_rdy;
    assign w_decide   = (w_first && w_eof)
                     || (w_hdr_xfer && (w_eof || (r_idx == idx_t'(HDR_WORDS - 1))));
    assign w_n        = (r_state == ST_IDLE) ? idx_t'(1) : r_idx + idx_t'(1);
    assign w_out_rdy  = r_sel_a ? a_dst_rdy : b_dst_rdy;
    assign w_last_rd  = (r_rd == r_n - idx_t'(1));

    // Header view at the decision cycle: buffered words plus the word arriving now
    always_comb begin
        for (int i = 0; i < HDR_WORDS; i++) begin
            w_hdr[i] = (idx_t'(i) == r_idx) ? in_data : r_buf[i];
        end
    end

    udp_hdr_match #(
        .MATCH_ETHERTYPE (MATCH_ETHERTYPE),
        .MATCH_PROTO     (MATCH_PROTO)
    ) u_match (
        .i_hdr      (w_hdr),
        .i_n_words  (w_n),
        .i_udp_port (udp_port),
        .o_route_a  (w_match_a)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_next       = r_state;
        w_in_dst_rdy = 1'b0;
        w_src_rdy    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_dst_rdy = 1'b1;
                if (w_first) begin
                    w_next = w_eof ? ST_REPLAY : ST_HDR;
                end
            end
            ST_HDR: begin
                w_in_dst_rdy = 1'b1;
                if (w_decide) begin
                    w_next = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                w_src_rdy = 1'b1;
                if (w_out_rdy && w_last_rd) begin
                    w_next = r_buf[r_rd][EOF_BIT] ? ST_IDLE : ST_PASS;
                end
            end
            ST_PASS: begin
                w_src_rdy    = in_src_rdy;
                w_in_dst_rdy = w_out_rdy;
                if (in_src_rdy && w_out_rdy && w_eof) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        if (clear) begin
            w_next = ST_IDLE;
        end
    end

    // Header buffer capture; contents are don't-care outside a frame so no reset
    always_ff @(posedge clk) begin
        if (w_first) begin
            r_buf[0] <= in_data;
        end else if (w_hdr_xfer) begin
            r_buf[r_idx] <= in_data;
        end
    end

    // Write index, replay pointer, route decision and frame counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx     <= '0;
            r_n       <= '0;
            r_rd      <= '0;
            r_sel_a   <= 1'b0;
            r_a_count <= '0;
            r_b_count <= '0;
        end else if (clear) begin
            r_idx <= '0;
            r_rd  <= '0;
        end else begin
            if (w_first) begin
                r_idx <= idx_t'(1);
            end else if (w_hdr_xfer) begin
                r_idx <= r_idx + idx_t'(1);
            end
            if (w_decide) begin
                r_n     <= w_n;
                r_rd    <= '0;
                r_sel_a <= w_match_a;
                if (w_match_a) begin
                    r_a_count <= r_a_count + 16'd1;
                end else begin
                    r_b_count <= r_b_count + 16'd1;
                end
            end else if ((r_state == ST_REPLAY) && w_out_rdy && !w_last_rd) begin
                r_rd <= r_rd + idx_t'(1);
            end
        end
    end

    // Shared output data mux: buffer during replay, live input during cut-through
    assign w_out_dat  = (r_state == ST_PASS) ? in_data : r_buf[r_rd];

    assign in_dst_rdy = w_in_dst_rdy & reset_n;
    assign a_src_rdy  = w_src_rdy & r_sel_a;
    assign b_src_rdy  = w_src_rdy & ~r_sel_a;
    assign a_data     = w_out_dat;
    assign b_data     = w_out_dat;
    assign a_count    = r_a_count;
    assign b_count    = r_b_count;

endmodule

// File: tb/tb_fifo36_udp_dispatch.sv
// Purpose: self-checking bench for fifo36_udp_dispatch (vector table + scoreboard).
// Latency: checks first-output timing after the decision word.
// Backpressure: exercises held, toggling and stalled output ready.
module tb_fifo36_udp_dispatch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] udp_port = '0;
    logic [35:0] in_data = '0;
    logic        in_src_rdy = 1'b0;
    logic        in_dst_rdy;
    logic [35:0] a_data, b_data;
    logic        a_src_rdy, b_src_rdy;
    logic        a_dst_rdy = 1'b1;
    logic        b_dst_rdy = 1'b1;
    logic [15:0] a_count, b_count;

    always #5 clk = ~clk;

    fifo36_udp_dispatch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .udp_port   (udp_port),
        .in_data    (in_data),
        .in_src_rdy (in_src_rdy),
        .in_dst_rdy (in_dst_rdy),
        .a_data     (a_data),
        .a_src_rdy  (a_src_rdy),
        .a_dst_rdy  (a_dst_rdy),
        .b_data     (b_data),
        .b_src_rdy  (b_src_rdy),
        .b_dst_rdy  (b_dst_rdy),
        .a_count    (a_count),
        .b_count    (b_count)
    );

    typedef struct {
        int          len;
        logic [15:0] etype;
        logic [7:0]  ipver;
        logic [7:0]  proto;
        logic [15:0] dport;
        logic [15:0] port;
        logic [1:0]  occ;
        bit          tog;
        bit          exp_a;
    } vec_t;

    typedef struct {
        bit          a;
        logic [35:0] d;
    } exp_t;

    vec_t        vt [12];
    exp_t        sbq [$];
    logic [35:0] fr [$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    int          exp_a_cnt = 0;
    int          exp_b_cnt = 0;
    int          rdy_mode = 0;   // 0 = always ready, 1 = toggle, 2 = stalled
    bit          ph = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Output ready pattern, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        ph = ~ph;
        a_dst_rdy = (rdy_mode == 0) || ((rdy_mode == 1) && ph);
        b_dst_rdy = (rdy_mode == 0) || ((rdy_mode == 1) && !ph);
    end

    task automatic pop_cmp(input bit is_a, input logic [35:0] d);
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got %s word 0x%0h, expected none", is_a ? "A" : "B", d);
        end else begin
            e = sbq.pop_front();
            check(is_a ? "out_word_a" : "out_word_b", {27'd0, is_a, d}, {27'd0, e.a, e.d});
            n_pops++;
        end
    endtask

    // Scoreboard monitor: every output transfer pops one expected word
    always @(negedge clk) begin
        if (a_src_rdy && b_src_rdy) begin
            check("both_src_rdy", 64'({a_src_rdy, b_src_rdy}), 64'b10);
        end
        if (a_src_rdy && a_dst_rdy) pop_cmp(1'b1, a_data);
        if (b_src_rdy && b_dst_rdy) pop_cmp(1'b0, b_data);
    end

    task automatic build_frame(input vec_t v);
        logic [31:0] p;
        logic [1:0]  occ;
        logic        eof, sof;
        fr.delete();
        for (int i = 0; i < v.len; i++) begin
            p = {8'(i), 8'hC3, 8'h5A, 8'(i * 7)};
            if (i == 3) p = {v.etype, v.ipver, 8'h00};
            if (i == 5) p = {8'(i), 16'h0040, v.proto};
            if (i == 9) p = {v.dport, 16'h5678};
            eof = (i == v.len - 1) ? 1'b1 : 1'b0;
            sof = (i == 0) ? 1'b1 : 1'b0;
            occ = eof ? v.occ : 2'b00;
            fr.push_back({occ, eof, sof, p});
        end
    endtask

    task automatic drive_word(input logic [35:0] w, output int cyc);
        bit got;
        got = 1'b0;
        cyc = 0;
        in_data = w;
        in_src_rdy = 1'b1;
        while (!got && cyc < 200) begin
            @(negedge clk); #1;
            got = in_dst_rdy;
            @(posedge clk); #1;
            cyc++;
        end
        if (!got) fail_msg("drive_word_timeout");
    endtask

    task automatic drain_and_idle();
        int cyc;
        cyc = 0;
        while (sbq.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        if (sbq.size() != 0) begin
            fail_msg("drain");
            sbq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
        check("a_count", 64'(a_count), 64'(exp_a_cnt[15:0]));
        check("b_count", 64'(b_count), 64'(exp_b_cnt[15:0]));
        // With outputs stalled only IDLE can still raise in_dst_rdy
        rdy_mode = 2;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("back_to_idle", 64'({in_dst_rdy, a_src_rdy, b_src_rdy}), 64'b100);
        rdy_mode = 0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input vec_t v);
        int  dec, base, cyc;
        bit  got, lat_pend, pd;
        build_frame(v);
        udp_port = v.port;
        rdy_mode = v.tog ? 1 : 0;
        base = n_pops;
        for (int i = 0; i < v.len; i++) sbq.push_back('{v.exp_a, fr[i]});
        if (v.exp_a) exp_a_cnt++; else exp_b_cnt++;
        dec = (v.len < 10) ? v.len - 1 : 9;
        lat_pend = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            in_data = fr[i];
            in_src_rdy = 1'b1;
            got = 1'b0;
            cyc = 0;
            while (!got && cyc < 200) begin
                pd = (n_pops - base) >= 10;
                @(negedge clk); #1;
                if (lat_pend) begin
                    check("first_out_latency", 64'(v.exp_a ? a_src_rdy : b_src_rdy), 64'd1);
                    lat_pend = 1'b0;
                end
                if (v.exp_a && v.tog && pd) begin
                    check("pass_in_dst_rdy", 64'(in_dst_rdy), 64'(a_dst_rdy));
                end
                got = in_dst_rdy;
                @(posedge clk); #1;
                cyc++;
            end
            if (!got) fail_msg("in_xfer_timeout");
            if (i == dec) lat_pend = 1'b1;
        end
        in_src_rdy = 1'b0;
        if (lat_pend) begin
            @(negedge clk); #1;
            check("first_out_latency", 64'(v.exp_a ? a_src_rdy : b_src_rdy), 64'd1);
        end
        drain_and_idle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        vec_t v;
        //           len etype     ipver  proto  dport     port     occ  tog  exp_a
        vt[0]  = '{16, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h1234, 2'd0, 1'b0, 1'b1};
        vt[1]  = '{16, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h1235, 2'd3, 1'b0, 1'b0};
        vt[2]  = '{ 4, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h1234, 2'd2, 1'b0, 1'b0};
        vt[3]  = '{10, 16'h0800, 8'h45, 8'h11, 16'hABCD, 16'hABCD, 2'd1, 1'b0, 1'b1};
        vt[4]  = '{11, 16'h0800, 8'h45, 8'h11, 16'h0035, 16'h0035, 2'd0, 1'b0, 1'b1};
        vt[5]  = '{ 9, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h1234, 2'd0, 1'b0, 1'b0};
        vt[6]  = '{16, 16'h86DD, 8'h45, 8'h11, 16'h1234, 16'h1234, 2'd0, 1'b0, 1'b0};
        vt[7]  = '{16, 16'h0800, 8'h46, 8'h11, 16'h1234, 16'h1234, 2'd0, 1'b0, 1'b0};
        vt[8]  = '{16, 16'h0800, 8'h45, 8'h06, 16'h1234, 16'h1234, 2'd0, 1'b0, 1'b0};
        vt[9]  = '{ 1, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h1234, 2'd1, 1'b0, 1'b0};
        vt[10] = '{16, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h1234, 2'd2, 1'b1, 1'b1};
        vt[11] = '{13, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h4321, 2'd0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_in_dst_rdy", 64'(in_dst_rdy), 64'd0);
        check("reset_src_rdy", 64'({a_src_rdy, b_src_rdy}), 64'd0);
        check("reset_counts", 64'({a_count, b_count}), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("idle_in_dst_rdy", 64'(in_dst_rdy), 64'd1);
        @(posedge clk); #1;

        // Table-driven frames
        for (int k = 0; k < 12; k++) send_frame(vt[k]);

        // Stray words with no sof are swallowed one per cycle
        for (int k = 0; k < 3; k++) begin
            drive_word({4'b0000, 32'hDEAD0000 + 32'(k)}, cyc);
            check("stray_accept_cycles", 64'(cyc), 64'd1);
        end
        in_src_rdy = 1'b0;
        send_frame(vt[0]);

        // Clear during replay: stall A, fill header, abort, then feed the tail
        v = vt[0];
        build_frame(v);
        udp_port = v.port;
        rdy_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) drive_word(fr[i], cyc);
        in_src_rdy = 1'b0;
        exp_a_cnt++;
        @(negedge clk); #1;
        check("replay_held_src_rdy", 64'(a_src_rdy), 64'd1);
        check("replay_held_data", 64'(a_data), 64'(fr[0]));
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk); #1;
        check("clear_stops_output", 64'({a_src_rdy, b_src_rdy}), 64'd0);
        check("clear_a_count", 64'(a_count), 64'(exp_a_cnt[15:0]));
        check("clear_b_count", 64'(b_count), 64'(exp_b_cnt[15:0]));
        rdy_mode = 0;
        for (int i = 10; i < 16; i++) begin
            drive_word(fr[i], cyc);
            check("tail_discard_cycles", 64'(cyc), 64'd1);
        end
        in_src_rdy = 1'b0;
        send_frame(vt[1]);
        send_frame(vt[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
